nor16_1: RTL and testbench

//  16-input NOR: out=1 only when all 16 input bits are 0.

---
 rtl/nor16_1.sv | 46 ++++
 tb/tb_nor16_1.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/nor16_1.sv
// 16-input NOR slice for the ALU zero flag: gate-level combinational out plus a registered copy.
// Optional sticky "zero seen" flag enabled by defining NOR16_STICKY_EN.
`timescale 10ps/1ps

module nor16_1 #(
  parameter int GATE_DELAY = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  output logic        out,
  output logic        out_q,
  output logic        seen_q
);

  logic [3:0] nor_grp;

  // Two-level tree: a NOR4 per nibble, then an AND4 of the four group results.
  nor #(GATE_DELAY) u_nor0 (nor_grp[0], in[0],  in[1],  in[2],  in[3]);
  nor #(GATE_DELAY) u_nor1 (nor_grp[1], in[4],  in[5],  in[6],  in[7]);
  nor #(GATE_DELAY) u_nor2 (nor_grp[2], in[8],  in[9],  in[10], in[11]);
  nor #(GATE_DELAY) u_nor3 (nor_grp[3], in[12], in[13], in[14], in[15]);
  and #(GATE_DELAY) u_and  (out, nor_grp[0], nor_grp[1], nor_grp[2], nor_grp[3]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out;
    end
  end

`ifdef NOR16_STICKY_EN
  // Sets on the same edge that captures out=1 and holds until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= 1'b0;
    end else if (out) begin
      seen_q <= 1'b1;
    end
  end
`else
  assign seen_q = 1'b0;
`endif

endmodule

// File: tb/tb_nor16_1.sv
// Directed bench for nor16_1: combinational delay bound, registered copy, reset and sticky flag.
`timescale 10ps/1ps

module tb_nor16_1;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        out;
  logic        out_q;
  logic        seen_q;

  int n_cmp;
  int n_bad;

  nor16_1 #(.GATE_DELAY(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in),
    .out    (out),
    .out_q  (out_q),
    .seen_q (seen_q)
  );

  // 1ns clock period (100 x 10ps)
  initial clk = 1'b0;
  always #50 clk = ~clk;

`ifdef NOR16_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  // Settle window: just past 2*GATE_DELAY = 100ps.
  task automatic settle();
    #10.1;
  endtask

  task automatic after_posedge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in    = 16'h0000;
    settle();
    n_cmp++;
    if (out_q !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_q: got %b want 0", out_q);
    end
    n_cmp++;
    if (seen_q !== 1'b0) begin
      n_bad++; $display("FAIL reset_seen_q: got %b want 0", seen_q);
    end
    n_cmp++;
    if (out !== 1'b1) begin
      n_bad++; $display("FAIL reset_out_valid: got %b want 1", out);
    end
    after_posedge();
    n_cmp++;
    if (out_q !== 1'b0) begin
      n_bad++; $display("FAIL reset_hold_out_q: got %b want 0", out_q);
    end
  endtask

  task automatic test_zero();
    @(negedge clk);
    rst_n = 1'b1;
    in    = 16'h0001;
    settle();
    n_cmp++;
    if (out !== 1'b0) begin
      n_bad++; $display("FAIL zero_pre_out: got %b want 0", out);
    end
    in = 16'h0000;
    settle();
    n_cmp++;
    if (out !== 1'b1) begin
      n_bad++; $display("FAIL zero_out_100ps: got %b want 1", out);
    end
    after_posedge();
    n_cmp++;
    if (out_q !== 1'b1) begin
      n_bad++; $display("FAIL zero_out_q: got %b want 1", out_q);
    end
    n_cmp++;
    if (seen_q !== STICKY) begin
      n_bad++; $display("FAIL zero_seen_q: got %b want %b", seen_q, STICKY);
    end
  endtask

  task automatic test_walking_one();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      v = 16'h0000;
      v[i] = 1'b1;
      in = v;
      settle();
      n_cmp++;
      if (out !== 1'b0) begin
        n_bad++; $display("FAIL walk_out bit=%0d: got %b want 0", i, out);
      end
      after_posedge();
      n_cmp++;
      if (out_q !== 1'b0) begin
        n_bad++; $display("FAIL walk_out_q bit=%0d: got %b want 0", i, out_q);
      end
    end
  endtask

  task automatic test_patterns();
    logic [15:0] vec [5] = '{16'hFFFF, 16'h8001, 16'h0000, 16'h0001, 16'h0000};
    logic        exp [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in = vec[i];
      settle();
      n_cmp++;
      if (out !== exp[i]) begin
        n_bad++; $display("FAIL pattern_out in=%h: got %b want %b", vec[i], out, exp[i]);
      end
      after_posedge();
      n_cmp++;
      if (out_q !== exp[i]) begin
        n_bad++; $display("FAIL pattern_out_q in=%h: got %b want %b", vec[i], out_q, exp[i]);
      end
    end
  endtask

  task automatic test_reset_midcycle();
    int cyc;
    @(negedge clk);
    in  = 16'h0000;
    cyc = 0;
    do begin
      after_posedge();
      cyc++;
    end while (out_q !== 1'b1 && cyc < 10);
    n_cmp++;
    if (out_q !== 1'b1) begin
      n_bad++; $display("FAIL midrst_reach_one: got %b want 1 within 10 cycles", out_q);
    end
    #24;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_q !== 1'b0) begin
      n_bad++; $display("FAIL midrst_out_q_async: got %b want 0", out_q);
    end
    n_cmp++;
    if (out !== 1'b1) begin
      n_bad++; $display("FAIL midrst_out_stays: got %b want 1", out);
    end
    n_cmp++;
    if (seen_q !== 1'b0) begin
      n_bad++; $display("FAIL midrst_seen_clear: got %b want 0", seen_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (out_q !== 1'b0) begin
      n_bad++; $display("FAIL midrst_no_capture_on_release: got %b want 0", out_q);
    end
    after_posedge();
    n_cmp++;
    if (out_q !== 1'b1) begin
      n_bad++; $display("FAIL midrst_first_capture: got %b want 1", out_q);
    end
  endtask

  task automatic test_sticky();
    @(negedge clk);
    in = 16'h0000;
    after_posedge();
    n_cmp++;
    if (seen_q !== STICKY) begin
      n_bad++; $display("FAIL sticky_set: got %b want %b", seen_q, STICKY);
    end
    @(negedge clk);
    in = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      after_posedge();
      n_cmp++;
      if (out_q !== 1'b0) begin
        n_bad++; $display("FAIL sticky_out_q cyc=%0d: got %b want 0", i, out_q);
      end
      n_cmp++;
      if (seen_q !== STICKY) begin
        n_bad++; $display("FAIL sticky_hold cyc=%0d: got %b want %b", i, seen_q, STICKY);
      end
    end
    #20;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (seen_q !== 1'b0) begin
      n_bad++; $display("FAIL sticky_clear: got %b want 0", seen_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    after_posedge();
    n_cmp++;
    if (seen_q !== 1'b0) begin
      n_bad++; $display("FAIL sticky_stay_clear: got %b want 0", seen_q);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    in    = 16'h0000;
    test_reset();
    test_zero();
    test_walking_one();
    test_patterns();
    test_reset_midcycle();
    test_sticky();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
